// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg - parametrised UART receiver.
//
// 16x oversampled receiver with 2-of-3 majority sampling at ticks 7/8/9 of
// every bit, configurable data width, parity and stop bits, and an output
// FIFO with a valid/ready handshake so downstream logic may stall.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high
//   rx          serial line (asynchronous, idle high)
//   rx_data     FIFO head word, LSB = first data bit received
//   rx_valid    FIFO not empty
//   rx_ready    consumer takes the head when rx_valid && rx_ready
//   fifo_count  number of words held
//   frame_err   one-cycle pulse: a stop bit was sampled 0
//   parity_err  one-cycle pulse: parity mismatch
//   overrun     one-cycle pulse: frame completed with FIFO full, word dropped
module uart_rx_cfg #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BPS        = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              rx,
    output logic [DATA_BITS-1:0]              rx_data,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              frame_err,
    output logic                              parity_err,
    output logic                              overrun
);

    localparam int DIV = CLK_HZ / (BPS * 16);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = $clog2(DATA_BITS);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int NW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    // 2-of-3 majority vote
    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Expected parity bit: even parity is the XOR of the data, odd its inverse
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    logic                 rx_meta_r, rx_sync_r;
    logic [2:0]           state_r;
    logic [CW-1:0]        baud_r;
    logic [3:0]           tick_cnt_r;
    logic [2:0]           samp_r;
    logic [BW-1:0]        bit_idx_r;
    logic                 stop_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_pend_r, frm_pend_r;
    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
    logic [NW-1:0]        count_r;

    logic                 tick_s, vote_s, done_s, pop_s, full_s, push_s, drop_s;
    logic [NW-1:0]        count_next_s;

    assign rx_data    = mem_r[rd_ptr_r];
    assign fifo_count = count_r;

    // Two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Tick, bit vote, frame completion and FIFO push/pop decisions
    always_comb begin
        tick_s       = 1'b0;
        vote_s       = 1'b0;
        done_s       = 1'b0;
        count_next_s = count_r;
        if ((state_r != ST_IDLE) && (baud_r == CW'(DIV - 1))) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        // At tick 9 the third sample is still on the line, not yet stored
        if (tick_cnt_r == 4'd9) begin
            vote_s = vote3(samp_r[0], samp_r[1], rx_sync_r);
        end else begin
            vote_s = vote3(samp_r[0], samp_r[1], samp_r[2]);
        end
        if (tick_s && (state_r == ST_STOP) && (tick_cnt_r == 4'd9) &&
            (stop_idx_r == 1'(STOP_BITS - 1))) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
        pop_s  = (count_r != {NW{1'b0}}) && rx_ready;
        full_s = (count_r == NW'(FIFO_DEPTH));
        push_s = done_s && (!full_s || pop_s);
        drop_s = done_s && full_s && !pop_s;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + NW'(1);
            2'b01:   count_next_s = count_r - NW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Baud divider and per-bit tick counter, both parked at zero while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_r     <= {CW{1'b0}};
            tick_cnt_r <= 4'd0;
        end else if (state_r == ST_IDLE) begin
            baud_r     <= {CW{1'b0}};
            tick_cnt_r <= 4'd0;
        end else if (baud_r == CW'(DIV - 1)) begin
            baud_r     <= {CW{1'b0}};
            tick_cnt_r <= tick_cnt_r + 4'd1;
        end else begin
            baud_r     <= baud_r + CW'(1);
        end
    end

    // Capture the three mid-bit samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_r <= 3'b111;
        end else if (tick_s) begin
            case (tick_cnt_r)
                4'd7:    samp_r[0] <= rx_sync_r;
                4'd8:    samp_r[1] <= rx_sync_r;
                4'd9:    samp_r[2] <= rx_sync_r;
                default: samp_r    <= samp_r;
            endcase
        end
    end

    // Frame state machine
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            bit_idx_r  <= {BW{1'b0}};
            stop_idx_r <= 1'b0;
            shift_r    <= {DATA_BITS{1'b0}};
            par_pend_r <= 1'b0;
            frm_pend_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!rx_sync_r) begin
                        state_r    <= ST_START;
                        par_pend_r <= 1'b0;
                        frm_pend_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick_s && (tick_cnt_r == 4'd9) && vote_s) begin
                        state_r <= ST_IDLE;
                    end else if (tick_s && (tick_cnt_r == 4'd15)) begin
                        state_r   <= ST_DATA;
                        bit_idx_r <= {BW{1'b0}};
                    end
                end
                ST_DATA: begin
                    if (tick_s && (tick_cnt_r == 4'd15)) begin
                        shift_r[bit_idx_r] <= vote_s;
                        if (bit_idx_r == BW'(DATA_BITS - 1)) begin
                            state_r    <= (PARITY != 0) ? ST_PAR : ST_STOP;
                            stop_idx_r <= 1'b0;
                        end else begin
                            bit_idx_r <= bit_idx_r + BW'(1);
                        end
                    end
                end
                ST_PAR: begin
                    if (tick_s && (tick_cnt_r == 4'd15)) begin
                        par_pend_r <= (vote_s != parity_bit(shift_r, (PARITY == 2)));
                        state_r    <= ST_STOP;
                        stop_idx_r <= 1'b0;
                    end
                end
                ST_STOP: begin
                    // Return to idle at the last stop decision, half a bit early
                    if (tick_s && (tick_cnt_r == 4'd9)) begin
                        if (!vote_s) begin
                            frm_pend_r <= 1'b1;
                        end
                        if (done_s) begin
                            state_r <= ST_IDLE;
                        end
                    end else if (tick_s && (tick_cnt_r == 4'd15)) begin
                        stop_idx_r <= 1'b1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Output FIFO plus registered status and error pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_BITS{1'b0}};
            end
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {NW{1'b0}};
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= shift_r;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r    <= count_next_s;
            rx_valid   <= (count_next_s != {NW{1'b0}});
            frame_err  <= done_s && (frm_pend_r || !vote_s);
            parity_err <= done_s && par_pend_r;
            overrun    <= drop_s;
        end
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver with 16x oversampling, majority-vote sampling, configurable frame format, error detection and an output FIFO with valid/ready handshake. It sits between the board RX pin and the command/display logic and supersedes the fixed 8N1 receiver. Received words are buffered so downstream logic may stall for up to FIFO_DEPTH frames without loss.

## Interface
- CLK_HZ, 100_000_000, system clock frequency
- BPS, 9600, baud rate; DIV = CLK_HZ/(BPS*16), integer division, must be ≥ 2
- DATA_BITS, 8, data bits per frame, 5..9
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 4, power of two, ≥ 2
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- rx  in  1  serial line, asynchronous to clk, idle high
- rx_data  out  DATA_BITS  FIFO head word, LSB = first bit received
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  consumer accepts head when rx_valid && rx_ready
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words held
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- parity_err  out  1  one-cycle pulse: parity mismatch (always 0 if PARITY = 0)
- overrun  out  1  one-cycle pulse: frame completed while FIFO full, word dropped

## Operation
- rx passes through a 2-FF synchronizer (reset value 1), giving rx_s; all decisions use rx_s.
- Baud counter is held at 0 in IDLE and runs 0..DIV-1 otherwise; tick = 1 cycle when counter == DIV-1. tick_cnt (4 bits) counts ticks 0..15 per bit period, wraps to 0 at each bit boundary.
- Sampling: rx_s captured on ticks 7, 8, 9; bit value = majority of the three (2-of-3).
- States: IDLE, START, DATA, PAR, STOP.
- IDLE: rx_s == 0 -> START, counter and tick_cnt cleared.
- START: at tick 9, majority == 1 -> IDLE (glitch rejected, no flags). Else at tick 15 -> DATA, bit index 0.
- DATA: at tick 15 store majority into shift register at bit index; after DATA_BITS bits -> PAR if PARITY != 0, else STOP.
- PAR: at tick 15 compare majority with expected (even: XOR of data; odd: inverted XOR); mismatch latched as pending parity error; -> STOP.
- STOP: each stop bit decided at tick 9; majority == 0 latches pending frame error. With 2 stop bits the first finishes at tick 15, the second decided at its tick 9. At the final stop decision -> IDLE in the same cycle (half-bit early so back-to-back start edges are caught); that cycle is the completion cycle.
- Completion: word pushed to FIFO regardless of errors; frame_err/parity_err pulse for that completion. If FIFO full and no pop in the same cycle: word dropped, overrun pulses, errors still flagged.
- FIFO: rx_data = head; pop on rx_valid && rx_ready. Push and pop in same cycle: both occur, count unchanged; when full this is not an overrun.
- Reset (any time, incl. mid-frame): state IDLE, FIFO emptied, counters 0, synchronizer 1.

## Timing
- Reset values: rx_data 0, rx_valid 0, fifo_count 0, frame_err 0, parity_err 0, overrun 0.
- Entering START at cycle T, tick k occurs at T + DIV*(k+1).
- Completion cycle: T + DIV*(16*(1+DATA_BITS+P+STOP_BITS-1) + 10), P = 1 if PARITY != 0.
- Error/overrun pulses and FIFO write take effect on the clock edge ending the completion cycle; rx_valid/fifo_count reflect it the next cycle.
- rx pin to START entry: 2 cycles (synchronizer) + 1.
- rx_data stable while rx_valid && !rx_ready.

## Test plan
- CLK_HZ 1_600_000, BPS 10_000 (DIV 10), 8N1: send 0xA5 -> rx_valid rises with rx_data 0xA5, fifo_count 1, no error pulses; rx_ready high one cycle -> rx_valid 0.
- Same config, rx low for 40 cycles then high -> no word, no flags, state back to IDLE; following 0x3C received correctly.
- PARITY 1, send 0x07 with parity bit 0 -> word 0x07 pushed, parity_err one pulse; PARITY 2 with parity bit 0 -> no parity_err.
- STOP_BITS 2, second stop bit driven 0 -> frame_err one pulse, word pushed; single-cycle 0 glitch at tick 8 of a data bit -> bit value unaffected.
- FIFO_DEPTH 4, rx_ready 0, send 5 back-to-back frames 0x01..0x05 -> fifo_count 4, overrun pulses on 5th; then drain -> 0x01,0x02,0x03,0x04 in order.
- Assert reset in the middle of DATA bit 4 -> all outputs at reset values, FIFO empty; next full frame 0x5A received correctly.
